instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO depth in entries (power of two, >=2).
REQ-002 Parameter CNT_W, default 8, width of the error counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_ctrl holds a control word to encode.
REQ-006 in_ready  output  1  block can accept a control word this cycle.
REQ-007 in_ctrl  input  32  packed control word: [31:23] reserved zero, [22] wr_regfile, [21:17] rs, [16:12] rt, [11:7] rd, [6] ctl_mux_alu, [5:3] alu_control, [2] cs, [1] wr, [0] ctl_mux_reg.
REQ-008 out_valid  output  1  out_instr holds an encoded instruction.
REQ-009 out_ready  input  1  downstream consumes out_instr this cycle.
REQ-010 out_instr  output  32  encoded instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] zero, [5:0] funct.
REQ-011 err_pulse  output  1  one-cycle strobe, illegal control word accepted.
REQ-012 err_count  output  CNT_W  saturating count of illegal words.
REQ-013 fifo_level  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-014 Accept occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 exactly when fifo_level < DEPTH, with no combinational dependence on out_ready.
REQ-016 R-type (wr_regfile=1, ctl_mux_alu=0, cs=0, wr=0, ctl_mux_reg=0, alu_control 0..4) SHALL encode op=1, rs, rt, rd, funct = 32/34/36/37/50 for alu_control 0/1/2/3/4.
REQ-017 Load (wr_regfile=1, ctl_mux_alu=1, cs=1, wr=0, ctl_mux_reg=1, alu_control=0, rd==rt) SHALL encode op=2, rs, rt, bits[15:0]=0.
REQ-018 Store (wr_regfile=0, ctl_mux_alu=1, cs=1, wr=1, ctl_mux_reg=1, alu_control=0, rd==rt) SHALL encode op=3, rs, rt, bits[15:0]=0.
REQ-019 All-zero control word SHALL encode as NOP 32'h00000000 and be enqueued.
REQ-020 Any other word (reserved bits nonzero, alu_control 5..7, load/store with rd!=rt, other flag combinations) is illegal: consumed, not enqueued, err_pulse=1 the following cycle.
REQ-021 err_count SHALL increment by one per illegal accept and hold at 2^CNT_W-1.
REQ-022 Accepted legal word SHALL appear at out_instr with out_valid=1 one cycle after accept if FIFO was empty (one-cycle latency); order is strict FIFO.
REQ-023 out_valid SHALL be 1 exactly when fifo_level > 0; out_instr SHALL be 32'h0 when empty.
REQ-024 out_instr and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 Simultaneous accept and pop SHALL leave fifo_level unchanged; illegal accept with pop decrements it.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; fifo_level never exceeds DEPTH nor underflows.

Reset
REQ-027 On rst=1 at a clock edge: fifo_level=0, pointers=0, out_valid=0, out_instr=0, err_pulse=0, err_count=0; in_ready=1 the cycle after.
REQ-028 Reset mid-operation SHALL discard all queued instructions and any pending err_pulse; reset overrides simultaneous accept/pop.

Verification
REQ-029 in_ctrl=32'h00422180 (add rs1 rt2 rd3), out_ready=1 -> next cycle out_valid=1, out_instr=32'h04221820.
REQ-030 in_ctrl=32'h004852C5 then 32'h000852C7 back-to-back -> out_instr 32'h08850000 then 32'h0C850000, in order.
REQ-031 in_ctrl=32'h004221A8 (alu_control=5) -> err_pulse=1 one cycle, err_count=1, fifo_level unchanged, no output.
REQ-032 out_ready=0, push 5 words of 32'h004221A0 -> first 4 accepted (out_instr=32'h04221832 held), in_ready=0 with fifo_level=4; release out_ready -> 4 pops then empty.
REQ-033 FIFO at level 2, rst pulsed with in_valid=1 -> fifo_level=0, out_valid=0, err_count=0, word not enqueued.

Source files
------------

// File: rtl/instr_encoder.sv
// Control-word to instruction encoder: decodes a packed control word, flags illegal
// words, and queues encoded instructions in a small output FIFO.
module instr_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_ctrl,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic                     err_pulse,
   output logic [CNT_W-1:0]         err_count,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef struct packed {
      logic        legal;
      logic [31:0] instr;
   } enc_t;

   // Only the exact R-type, load, store and all-zero patterns are legal.
   function automatic enc_t encode_ctrl(input logic [31:0] c);
      enc_t       r;
      logic [4:0] flags;
      logic [5:0] funct;
      r     = '0;
      flags = {c[22], c[6], c[2], c[1], c[0]};
      funct = 6'd0;
      if (c == 32'h0) begin
         r.legal = 1'b1;
      end else if (c[31:23] != 9'd0) begin
         r.legal = 1'b0;
      end else if (flags == 5'b10000) begin
         case (c[5:3])
            3'd0:    begin r.legal = 1'b1; funct = 6'd32; end
            3'd1:    begin r.legal = 1'b1; funct = 6'd34; end
            3'd2:    begin r.legal = 1'b1; funct = 6'd36; end
            3'd3:    begin r.legal = 1'b1; funct = 6'd37; end
            3'd4:    begin r.legal = 1'b1; funct = 6'd50; end
            default: r.legal = 1'b0;
         endcase
         r.instr = {6'd1, c[21:17], c[16:12], c[11:7], 5'd0, funct};
      end else if (c[5:3] == 3'd0 && c[11:7] == c[16:12] &&
                   (flags == 5'b11101 || flags == 5'b01111)) begin
         r.legal = 1'b1;
         r.instr = {(flags[1] ? 6'd3 : 6'd2), c[21:17], c[16:12], 16'd0};
      end
      if (!r.legal) r.instr = 32'h0;
      return r;
   endfunction

   // Stage p0: decode of the word presented this cycle
   enc_t        enc_p0;
   logic        accept_p0;
   logic        push_p0;
   logic        pop_p0;

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_comb begin
      enc_p0    = encode_ctrl(in_ctrl);
      accept_p0 = in_valid && in_ready;
      push_p0   = accept_p0 && enc_p0.legal;
      pop_p0    = out_valid && out_ready;
   end

   // Stage p1: FIFO state, error strobe and counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
      end else begin
         if (push_p0) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_p0)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_p0, pop_p0})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: fifo_level <= fifo_level;
         endcase
         err_pulse <= accept_p0 && !enc_p0.legal;
         if (accept_p0 && !enc_p0.legal && err_count != {CNT_W{1'b1}})
            err_count <= err_count + CNT_W'(1);
      end
   end

   // Storage carries no reset; the level count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_p0 && !rst) mem[wr_ptr] <= enc_p0.instr;
   end

   assign in_ready  = fifo_level < LVL_W'(DEPTH);
   assign out_valid = fifo_level != '0;
   assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instr_encoder;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_ctrl = 32'h0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_instr;
   logic              err_pulse;
   logic [CNT_W-1:0]  err_count;
   logic [$clog2(DEPTH):0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   bit          m_pulse = 0;
   int          m_cnt   = 0;

   instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .err_pulse(err_pulse), .err_count(err_count),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // Reference encoding straight from the field definitions.
   function automatic bit ref_encode(input logic [31:0] c, output logic [31:0] ins);
      int funct_tab[5] = '{32, 34, 36, 37, 50};
      int rsv = int'(c >> 23);
      int wrf = int'((c >> 22) & 1);
      int rs  = int'((c >> 17) & 31);
      int rt  = int'((c >> 12) & 31);
      int rd  = int'((c >> 7) & 31);
      int ma  = int'((c >> 6) & 1);
      int alu = int'((c >> 3) & 7);
      int cs  = int'((c >> 2) & 1);
      int wr  = int'((c >> 1) & 1);
      int mr  = int'(c & 1);
      ins = 32'h0;
      if (c == 32'h0) return 1'b1;
      if (rsv != 0) return 1'b0;
      if (wrf == 1 && ma == 0 && cs == 0 && wr == 0 && mr == 0 && alu <= 4) begin
         ins = 32'((1 << 26) + (rs << 21) + (rt << 16) + (rd << 11) + funct_tab[alu]);
         return 1'b1;
      end
      if (ma == 1 && cs == 1 && mr == 1 && alu == 0 && rd == rt && wrf + wr == 1) begin
         ins = 32'(((wrf == 1 ? 2 : 3) << 26) + (rs << 21) + (rt << 16));
         return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] rand_ctrl();
      logic [4:0]  rs = 5'($urandom);
      logic [4:0]  rt = 5'($urandom);
      logic [4:0]  rd = 5'($urandom);
      logic [2:0]  alu = 3'($urandom);
      logic [31:0] w;
      case ($urandom_range(0, 6))
         0: w = {9'd0, 1'b1, rs, rt, rd, 1'b0, alu, 3'b000};
         1: w = {9'd0, 1'b1, rs, rt, ($urandom_range(0, 3) == 0 ? rd : rt), 1'b1,
                 ($urandom_range(0, 4) == 0 ? alu : 3'd0), 3'b101};
         2: w = {9'd0, 1'b0, rs, rt, ($urandom_range(0, 3) == 0 ? rd : rt), 1'b1,
                 ($urandom_range(0, 4) == 0 ? alu : 3'd0), 3'b111};
         3: w = 32'h0;
         4: w = $urandom;
         5: w = {9'd0, 1'b1, rs, rt, rd, 1'b0, alu, 3'b000} ^ (32'h1 << $urandom_range(0, 7));
         default: w = {9'd0, 1'b1, rs, rt, rd, 1'b0, 3'd1, 3'b000} | (32'h1 << $urandom_range(23, 31));
      endcase
      return w;
   endfunction

   // Advance one clock and apply the same edge to the model; returns 1 ns after the edge.
   task automatic cycle();
      logic [31:0] ins;
      bit          acc, pop;
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         m_pulse = 0;
         m_cnt   = 0;
      end else begin
         acc = in_valid && (exp_q.size() < DEPTH);
         pop = out_ready && (exp_q.size() > 0);
         if (pop) void'(exp_q.pop_front());
         m_pulse = 0;
         if (acc) begin
            if (ref_encode(in_ctrl, ins)) exp_q.push_back(ins);
            else begin
               m_pulse = 1;
               if (m_cnt < CNT_MAX) m_cnt++;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_ctrl = 32'h00422180; out_ready = 1'b0;
      cycle(); cycle();
      rst = 1'b0; in_valid = 1'b0;
      n_checks++; if (fifo_level !== 0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
      n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
      n_checks++; if (err_count !== 0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_rtype();
      in_valid = 1'b1; in_ctrl = 32'h00422180; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rtype_valid got %b want 1", out_valid); end
      n_checks++; if (out_instr !== 32'h04221820) begin n_fail++; $display("FAIL rtype_instr got %h want 04221820", out_instr); end
      cycle();
      n_checks++; if (fifo_level !== 0 || out_instr !== 32'h0) begin
         n_fail++; $display("FAIL rtype_drain got level %0d instr %h want 0 0", fifo_level, out_instr); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0; in_valid = 1'b1;
      in_ctrl = 32'h004852C5; cycle();
      in_ctrl = 32'h000852C7; cycle();
      in_valid = 1'b0;
      n_checks++; if (out_instr !== 32'h08850000 || fifo_level !== 2) begin
         n_fail++; $display("FAIL b2b_first got %h level %0d want 08850000 level 2", out_instr, fifo_level); end
      out_ready = 1'b1; cycle();
      n_checks++; if (out_instr !== 32'h0C850000 || fifo_level !== 1) begin
         n_fail++; $display("FAIL b2b_second got %h level %0d want 0c850000 level 1", out_instr, fifo_level); end
      cycle();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      int cnt0 = int'(err_count);
      in_valid = 1'b1; in_ctrl = 32'h004221A8; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse got %b want 1", err_pulse); end
      n_checks++; if (int'(err_count) !== cnt0 + 1) begin n_fail++; $display("FAIL illegal_count got %0d want %0d", err_count, cnt0 + 1); end
      n_checks++; if (fifo_level !== 0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL illegal_noenq got level %0d valid %b want 0 0", fifo_level, out_valid); end
      cycle();
      n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width got %b want 0", err_pulse); end
   endtask

   task automatic test_full();
      int exp_lvl;
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 32'h004221A0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         exp_lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
         n_checks++; if (int'(fifo_level) !== exp_lvl || in_ready !== (exp_lvl < DEPTH)) begin
            n_fail++; $display("FAIL full_fill%0d got level %0d ready %b want %0d %b", i, fifo_level, in_ready, exp_lvl, exp_lvl < DEPTH); end
         n_checks++; if (out_instr !== 32'h04221832 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_hold%0d got %h valid %b want 04221832 1", i, out_instr, out_valid); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         cycle();
         n_checks++; if (int'(fifo_level) !== DEPTH - 1 - i) begin
            n_fail++; $display("FAIL full_drain%0d got %0d want %0d", i, fifo_level, DEPTH - 1 - i); end
      end
      n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
         n_fail++; $display("FAIL full_empty got valid %b instr %h want 0 0", out_valid, out_instr); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1;
      in_ctrl = 32'h00422180; cycle();
      in_ctrl = 32'h004852C5; cycle();
      in_ctrl = 32'h004221A8; cycle();
      n_checks++; if (fifo_level !== 2 || err_pulse !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre got level %0d pulse %b want 2 1", fifo_level, err_pulse); end
      rst = 1'b1; in_ctrl = 32'h00422180; out_ready = 1'b1;
      cycle();
      rst = 1'b0; in_valid = 1'b0;
      n_checks++; if (fifo_level !== 0 || out_valid !== 1'b0 || out_instr !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_fifo got level %0d valid %b instr %h want 0 0 0", fifo_level, out_valid, out_instr); end
      n_checks++; if (err_count !== 0 || err_pulse !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_err got count %0d pulse %b ready %b want 0 0 1", err_count, err_pulse, in_ready); end
      cycle();
      n_checks++; if (fifo_level !== 0) begin n_fail++; $display("FAIL rstmid_noenq got %0d want 0", fifo_level); end
   endtask

   task automatic test_saturation();
      in_valid = 1'b1; in_ctrl = 32'hFFFF_FFFF; out_ready = 1'b1;
      for (int i = 0; i < CNT_MAX + 6; i++) cycle();
      in_valid = 1'b0;
      n_checks++; if (int'(err_count) !== CNT_MAX || err_pulse !== 1'b1) begin
         n_fail++; $display("FAIL sat_count got %0d pulse %b want %0d 1", err_count, err_pulse, CNT_MAX); end
      cycle();
      n_checks++; if (int'(err_count) !== CNT_MAX || fifo_level !== 0) begin
         n_fail++; $display("FAIL sat_hold got %0d level %0d want %0d 0", err_count, fifo_level, CNT_MAX); end
   endtask

   task automatic test_random();
      logic [31:0] exp_out;
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_ctrl   = rand_ctrl();
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
         exp_out = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
         n_checks++; if (int'(fifo_level) !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_level@%0d got %0d want %0d", i, fifo_level, exp_q.size()); end
         n_checks++; if (out_valid !== (exp_q.size() > 0) || out_instr !== exp_out) begin
            n_fail++; $display("FAIL rand_out@%0d got %b %h want %b %h", i, out_valid, out_instr, exp_q.size() > 0, exp_out); end
         n_checks++; if (in_ready !== (exp_q.size() < DEPTH)) begin
            n_fail++; $display("FAIL rand_ready@%0d got %b want %b", i, in_ready, exp_q.size() < DEPTH); end
         n_checks++; if (err_pulse !== m_pulse || int'(err_count) !== m_cnt) begin
            n_fail++; $display("FAIL rand_err@%0d got %b %0d want %b %0d", i, err_pulse, err_count, m_pulse, m_cnt); end
      end
      rst = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_rtype();
      test_back_to_back();
      test_illegal();
      test_full();
      test_reset_mid();
      test_saturation();
      test_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
